hazard_forward_ctrl: RTL

Hazard and forwarding controller for the pipelined CPU: drives the 2-bit selects of the two EX-stage operand forwarding muxes and the stall/flush controls for the F/D/E pipeline registers. It keeps its own shadow copy of destination-register information for the E, M and W stages, fed from decode-stage fields. It resolves RAW hazards by forwarding, load-use hazards by a one-cycle stall plus bubble, and taken branches by flushing. It also counts stall cycles for performance measurement.

---
 rtl/hazard_forward_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
// Hazard and forwarding controller for a five-stage pipelined CPU.
// - Keeps a shadow copy of the register-address/control fields for the E, M and W stages.
// - Resolves RAW hazards by forwarding into the EX operand muxes.
// - Resolves load-use hazards with a one-cycle stall plus a bubble in E.
// - Flushes D and E when a taken branch resolves in E.
// - Counts stall cycles, saturating at all-ones.
// Optional feature macro: HAZARD_ZERO_REG_EN.
// - When defined, register 0 is hard-wired: it never forwards and never stalls.
// - When undefined, register 0 behaves like any other register.
// There are no handshakes: every control output is a pure function of the
// shadow registers and the current D-stage inputs, valid in the same cycle.
module hazard_forward_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] WA3D,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  PCSrcE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUOUTM = 2'b10;

  // E-stage shadow fields
  logic [REG_ADDR_W-1:0] ra1e_q, ra1e_d;
  logic [REG_ADDR_W-1:0] ra2e_q, ra2e_d;
  logic [REG_ADDR_W-1:0] wa3e_q, wa3e_d;
  logic                  regwritee_q, regwritee_d;
  logic                  memtorege_q, memtorege_d;

  // M-stage shadow fields
  logic [REG_ADDR_W-1:0] wa3m_q;
  logic                  regwritem_q;

  // W-stage shadow fields
  logic [REG_ADDR_W-1:0] wa3w_q;
  logic                  regwritew_q;

  // Stall cycle counter
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  // Internal (ungated) hazard terms
  logic                  regwrite_d_eff;
  logic                  src1d_ok;
  logic                  src2d_ok;
  logic                  src1e_ok;
  logic                  src2e_ok;
  logic                  ldstall;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  stall_int;
  logic                  flush_d_int;
  logic                  flush_e_int;

`ifdef HAZARD_ZERO_REG_EN
  // Register 0 is hard-wired: writes to it never count as writes, and a
  // source of 0 never matches a producer.
  assign regwrite_d_eff = RegWriteD && (WA3D != '0);
  assign src1d_ok       = (RA1D != '0);
  assign src2d_ok       = (RA2D != '0);
  assign src1e_ok       = (ra1e_q != '0);
  assign src2e_ok       = (ra2e_q != '0);
`else
  // Register 0 is an ordinary register.
  assign regwrite_d_eff = RegWriteD;
  assign src1d_ok       = 1'b1;
  assign src2d_ok       = 1'b1;
  assign src1e_ok       = 1'b1;
  assign src2e_ok       = 1'b1;
`endif

  // Operand forwarding select: M has priority over W, otherwise register file.
  always_comb begin
    fwd_a = FWD_REGFILE;
    fwd_b = FWD_REGFILE;
    if (src1e_ok && regwritem_q && (wa3m_q == ra1e_q)) begin
      fwd_a = FWD_ALUOUTM;
    end else if (src1e_ok && regwritew_q && (wa3w_q == ra1e_q)) begin
      fwd_a = FWD_RESULTW;
    end
    if (src2e_ok && regwritem_q && (wa3m_q == ra2e_q)) begin
      fwd_b = FWD_ALUOUTM;
    end else if (src2e_ok && regwritew_q && (wa3w_q == ra2e_q)) begin
      fwd_b = FWD_RESULTW;
    end
  end

  // Load-use detection and stall/flush decisions; a taken branch overrides a stall.
  always_comb begin
    ldstall     = memtorege_q && regwritee_q &&
                  ((src1d_ok && (wa3e_q == RA1D)) ||
                   (src2d_ok && (wa3e_q == RA2D)));
    stall_int   = ldstall && !PCSrcE;
    flush_d_int = PCSrcE;
    flush_e_int = ldstall || PCSrcE;
  end

  // All control outputs are held at zero while reset is asserted.
  always_comb begin
    ForwardAE = rst ? FWD_REGFILE : fwd_a;
    ForwardBE = rst ? FWD_REGFILE : fwd_b;
    StallF    = rst ? 1'b0 : stall_int;
    StallD    = rst ? 1'b0 : stall_int;
    FlushD    = rst ? 1'b0 : flush_d_int;
    FlushE    = rst ? 1'b0 : flush_e_int;
  end

  // Next E contents: D fields, or an all-zero bubble when E is flushed.
  always_comb begin
    ra1e_d      = RA1D;
    ra2e_d      = RA2D;
    wa3e_d      = WA3D;
    regwritee_d = regwrite_d_eff;
    memtorege_d = MemtoRegD;
    if (flush_e_int) begin
      ra1e_d      = '0;
      ra2e_d      = '0;
      wa3e_d      = '0;
      regwritee_d = 1'b0;
      memtorege_d = 1'b0;
    end
  end

  // Saturating stall counter next value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_int && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Shadow pipeline advance (W<=M, M<=E, E<=D or bubble) with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra1e_q      <= '0;
      ra2e_q      <= '0;
      wa3e_q      <= '0;
      regwritee_q <= 1'b0;
      memtorege_q <= 1'b0;
      wa3m_q      <= '0;
      regwritem_q <= 1'b0;
      wa3w_q      <= '0;
      regwritew_q <= 1'b0;
    end else begin
      ra1e_q      <= ra1e_d;
      ra2e_q      <= ra2e_d;
      wa3e_q      <= wa3e_d;
      regwritee_q <= regwritee_d;
      memtorege_q <= memtorege_d;
      wa3m_q      <= wa3e_q;
      regwritem_q <= regwritee_q;
      wa3w_q      <= wa3m_q;
      regwritew_q <= regwritem_q;
    end
  end

  // Stall cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule
